// File: rtl/mandelbrot_pkg.sv
// Shared constants, types and palette for the Mandelbrot VGA scan-out.
// Timing defaults describe 640x480@60 on a 25 MHz pixel clock.
package mandelbrot_pkg;
  localparam int X_PIXELS = 640;
  localparam int Y_PIXELS = 480;
  localparam int MEM_MAX  = X_PIXELS * Y_PIXELS - 1;
  localparam int ADDR_W   = 19;
  localparam logic [7:0] IN_SET_VALUE = 8'hFF;

  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Per-pixel control carried down the pipeline beside the memory read.
  typedef struct packed {
    logic fs;
    logic de;
    logic hs;
    logic vs;
    logic en;
  } ctrl_t;

  // Escape count bits replicated into each channel; points inside the set are black.
  function automatic rgb_t palette(input logic [7:0] d);
    rgb_t c;
    c = '0;
    if (d != IN_SET_VALUE) begin
      c.r = {d[7:5], d[7:5], d[7:6]};
      c.g = {d[4:2], d[4:2], d[4:3]};
      c.b = {4{d[1:0]}};
    end
    return c;
  endfunction
endpackage

// File: rtl/mandelbrot_vga_timing.sv
// Free-running h/v raster counters with stage-0 decode of visible area, syncs and frame origin.
// Decode is combinational from the counter registers; no backpressure, runs every pixel clock.
module mandelbrot_vga_timing
  import mandelbrot_pkg::*;
#(
  parameter int H_VISIBLE = X_PIXELS,
  parameter int V_VISIBLE = Y_PIXELS,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic o_de,
  output logic o_hsync,
  output logic o_vsync,
  output logic o_origin
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  logic [HW-1:0] r_hcount;
  logic [VW-1:0] r_vcount;
  logic          w_hwrap;
  logic          w_vwrap;

  assign w_hwrap = (r_hcount == HW'(H_TOTAL - 1));
  assign w_vwrap = (r_vcount == VW'(V_TOTAL - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hcount <= '0;
      r_vcount <= '0;
    end else if (w_hwrap) begin
      r_hcount <= '0;
      r_vcount <= w_vwrap ? '0 : r_vcount + 1'b1;
    end else begin
      r_hcount <= r_hcount + 1'b1;
    end
  end

  assign o_de     = (r_hcount < HW'(H_VISIBLE)) && (r_vcount < VW'(V_VISIBLE));
  assign o_hsync  = (r_hcount >= HW'(H_VISIBLE + H_FP)) &&
                    (r_hcount <  HW'(H_VISIBLE + H_FP + H_SYNC));
  assign o_vsync  = (r_vcount >= VW'(V_VISIBLE + V_FP)) &&
                    (r_vcount <  VW'(V_VISIBLE + V_FP + V_SYNC));
  assign o_origin = (r_hcount == '0) && (r_vcount == '0);
endmodule

// File: rtl/mandelbrot_vga_scanout.sv
// Scans a rendered framebuffer out to VGA through a palette; all outputs 3 clocks behind the raster.
// No backpressure: memory must return data exactly one clock after each address.
module mandelbrot_vga_scanout
  import mandelbrot_pkg::*;
#(
  parameter int H_VISIBLE = X_PIXELS,
  parameter int V_VISIBLE = Y_PIXELS,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_valid,
  output logic [ADDR_W-1:0] mem_read_address,
  input  logic [7:0]        mem_read_data,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              hsync_n,
  output logic              vsync_n,
  output logic              de,
  output logic              frame_start
);
  logic              w_de;
  logic              w_hsync;
  logic              w_vsync;
  logic              w_origin;
  ctrl_t             w_s0;
  ctrl_t             r_s1;
  ctrl_t             r_s2;
  rgb_t              r_rgb;
  logic              r_display_en;
  logic              r_hsync_n;
  logic              r_vsync_n;
  logic              r_de;
  logic              r_frame_start;
  logic [ADDR_W-1:0] r_addr;

  mandelbrot_vga_timing #(
    .H_VISIBLE(H_VISIBLE), .V_VISIBLE(V_VISIBLE),
    .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk     (clk),
    .reset   (reset),
    .o_de    (w_de),
    .o_hsync (w_hsync),
    .o_vsync (w_vsync),
    .o_origin(w_origin)
  );

  // Pixel (0,0) already uses the fresh frame_valid sample so a frame is never split.
  always_comb begin
    w_s0    = '0;
    w_s0.fs = w_origin;
    w_s0.de = w_de;
    w_s0.hs = w_hsync;
    w_s0.vs = w_vsync;
    w_s0.en = w_origin ? frame_valid : r_display_en;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_display_en  <= 1'b0;
      r_addr        <= '0;
      r_s1          <= '0;
      r_s2          <= '0;
      r_rgb         <= '0;
      r_hsync_n     <= 1'b1;
      r_vsync_n     <= 1'b1;
      r_de          <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      if (w_origin) r_display_en <= frame_valid;
      // Linear address walks visible pixels only and holds through blanking.
      if (w_de) r_addr <= w_origin ? '0 : r_addr + 1'b1;
      r_s1          <= w_s0;
      r_s2          <= r_s1;
      r_rgb         <= (r_s2.de && r_s2.en) ? palette(mem_read_data) : '0;
      r_hsync_n     <= ~r_s2.hs;
      r_vsync_n     <= ~r_s2.vs;
      r_de          <= r_s2.de;
      r_frame_start <= r_s2.fs;
    end
  end

  assign mem_read_address = r_addr;
  assign vga_r            = r_rgb.r;
  assign vga_g            = r_rgb.g;
  assign vga_b            = r_rgb.b;
  assign hsync_n          = r_hsync_n;
  assign vsync_n          = r_vsync_n;
  assign de               = r_de;
  assign frame_start      = r_frame_start;
endmodule

// File: tb/tb_mandelbrot_vga_scanout.sv
// Self-checking bench for mandelbrot_vga_scanout on a shrunken raster, against a raster-position model.
module tb_mandelbrot_vga_scanout;
  localparam int HV = 32, VV = 12, HFP = 2, HS = 3, HBP = 3, VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HV + HFP + HS + HBP;
  localparam int VT = VV + VFP + VS + VBP;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        frame_valid = 1'b0;
  logic [18:0] mem_read_address;
  logic [7:0]  mem_read_data;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        hsync_n, vsync_n, de, frame_start;

  logic [7:0] lut [256];
  bit         en [64];
  bit         fv;
  int         cyc, errors, checks;
  int         de_line, de_frame, fs_frame;

  mandelbrot_vga_scanout #(
    .H_VISIBLE(HV), .V_VISIBLE(VV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .frame_valid     (frame_valid),
    .mem_read_address(mem_read_address),
    .mem_read_data   (mem_read_data),
    .vga_r           (vga_r),
    .vga_g           (vga_g),
    .vga_b           (vga_b),
    .hsync_n         (hsync_n),
    .vsync_n         (vsync_n),
    .de              (de),
    .frame_start     (frame_start)
  );

  always #5 clk = ~clk;

  // Framebuffer: contents repeat every 256 addresses, one clock read latency.
  always @(posedge clk) mem_read_data <= lut[mem_read_address[7:0]];

  function automatic logic [23:0] pal(input logic [7:0] d);
    int r3, g3, b2, r, g, b;
    if (d == 8'd255) return 24'h0;
    r3 = int'(d) / 32;
    g3 = (int'(d) / 4) % 8;
    b2 = int'(d) % 4;
    r  = r3 * 32 + r3 * 4 + r3 / 2;
    g  = g3 * 32 + g3 * 4 + g3 / 2;
    b  = b2 * 85;
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  task automatic chk(input string tag, input int t, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, got, exp);
    end
  endtask

  // t counts cycles since reset release; outputs show raster position t-3.
  task automatic check_cycle(input int t);
    int p, h, v, f, p1, h1, v1, ea;
    logic [23:0] ergb;
    logic ehs, evs, ede, efs;
    h = 0; v = 0; p = 0;
    if (t == 0) ea = 0;
    else begin
      p1 = t - 1;
      h1 = p1 % HT;
      v1 = (p1 / HT) % VT;
      if (v1 >= VV)      ea = VV * HV - 1;
      else if (h1 >= HV) ea = v1 * HV + HV - 1;
      else               ea = v1 * HV + h1;
    end
    if (t < 3) begin
      ehs = 1'b1; evs = 1'b1; ede = 1'b0; efs = 1'b0; ergb = 24'h0;
    end else begin
      p   = t - 3;
      h   = p % HT;
      v   = (p / HT) % VT;
      f   = p / FRAME;
      ede = (h < HV) && (v < VV);
      ehs = !((h >= HV + HFP) && (h < HV + HFP + HS));
      evs = !((v >= VV + VFP) && (v < VV + VFP + VS));
      efs = (h == 0) && (v == 0);
      ergb = (ede && en[f % 64]) ? pal(lut[(v * HV + h) % 256]) : 24'h0;
    end
    chk("addr", t, 32'(mem_read_address), ea);
    chk("rgb", t, {8'h0, vga_r, vga_g, vga_b}, {8'h0, ergb});
    chk("hsync_n", t, 32'(hsync_n), 32'(ehs));
    chk("vsync_n", t, 32'(vsync_n), 32'(evs));
    chk("de", t, 32'(de), 32'(ede));
    chk("frame_start", t, 32'(frame_start), 32'(efs));
    if (t >= 3) begin
      if (de === 1'b1) begin de_line++; de_frame++; end
      if (frame_start === 1'b1) fs_frame++;
      if (h == HT - 1) begin
        chk("de_per_line", t, de_line, (v < VV) ? HV : 0);
        de_line = 0;
      end
      if (p % FRAME == FRAME - 1) begin
        chk("de_per_frame", t, de_frame, HV * VV);
        chk("fs_per_frame", t, fs_frame, 1);
        de_frame = 0;
        fs_frame = 0;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b1;
      frame_valid = fv;
      if (cyc % FRAME == 0) en[(cyc / FRAME) % 64] = fv;
      #1 check_cycle(cyc);
      cyc++;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b0;
    frame_valid = fv;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      chk("rst_addr", i, 32'(mem_read_address), 0);
      chk("rst_rgb", i, {8'h0, vga_r, vga_g, vga_b}, 0);
      chk("rst_hsync_n", i, 32'(hsync_n), 1);
      chk("rst_vsync_n", i, 32'(vsync_n), 1);
      chk("rst_de", i, 32'(de), 0);
      chk("rst_frame_start", i, 32'(frame_start), 0);
    end
    cyc = 0;
    de_line = 0;
    de_frame = 0;
    fs_frame = 0;
  endtask

  initial begin
    int k;
    errors = 0; checks = 0; cyc = 0; fv = 1'b0;
    for (int i = 0; i < 256; i++) lut[i] = 8'(i);

    // Display disabled: syncs and address run, picture stays black.
    do_reset(3);
    run(2 * FRAME + 10);

    // Display enabled before the origin: identity framebuffer coloured from pixel 0.
    fv = 1'b1;
    do_reset(1);
    run(2 * FRAME + 10);

    // Random framebuffer with the four reference bytes at the start.
    for (int i = 0; i < 256; i++) lut[i] = 8'($urandom);
    lut[0] = 8'h00; lut[1] = 8'h2D; lut[2] = 8'hFE; lut[3] = 8'hFF;
    fv = 1'b0;
    do_reset(1);
    k = $urandom_range(FRAME - 100, 40);
    run(k);
    fv = 1'b1;
    run(FRAME - k + 200);
    fv = 1'b0;
    run(2 * FRAME - 200 + 10);

    // Reset in the middle of a line, then a coloured frame from the origin.
    fv = 1'b1;
    run(3 * FRAME + 5 * HT + 10 - cyc);
    do_reset(1);
    run(FRAME + 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
